mult_unit: RTL and testbench

- Multi-cycle signed multiplier for MULT. It sits directly downstream of the control unit.
- The control unit pulses multControl with rs/rt on the operand inputs. It then waits for multDone and pulses writeHI/writeLO to commit hiOut/loOut into the HI/LO registers.
- Radix-2 Booth algorithm, one step per clock, WIDTH steps per operation.

---
 rtl/mult_unit.sv | 100 ++++++++++
 tb/tb_mult_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_unit.sv
// mult_unit: multi-cycle signed multiplier for MULT, fed by the control unit.
// It uses a radix-2 Booth recoding and performs one step per clock, with WIDTH steps per product.
// The result is committed to hiOut/loOut only at completion, so the control unit
// can read a stable HI/LO pair whenever multDone pulses.

module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             multControl,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic [WIDTH-1:0] hiOut,
  output logic [WIDTH-1:0] loOut,
  output logic             multBusy,
  output logic             multDone
);

  localparam int CountWidth = $clog2(WIDTH + 1);
  localparam logic [CountWidth-1:0] LastStep = CountWidth'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } multState_e;

  multState_e             multState;
  logic [WIDTH:0]         accA;
  logic [WIDTH-1:0]       multM;
  logic [WIDTH-1:0]       multQ;
  logic                   qMinus1;
  logic [CountWidth-1:0]  stepCount;

  logic [WIDTH:0]         mExt;
  logic [WIDTH:0]         boothSum;
  logic [WIDTH:0]         nextA;
  logic [WIDTH-1:0]       nextQ;
  logic                   nextQMinus1;

  // One Booth step: the accumulator is one bit wider than the operands, so the most negative multiplicand is subtracted exactly.
  always_comb begin
    mExt = {multM[WIDTH-1], multM};
    boothSum = accA;
    case ({multQ[0], qMinus1})
      2'b01:   boothSum = accA + mExt;
      2'b10:   boothSum = accA - mExt;
      default: boothSum = accA;
    endcase
    nextA       = {boothSum[WIDTH], boothSum[WIDTH:1]};
    nextQ       = {boothSum[0], multQ[WIDTH-1:1]};
    nextQMinus1 = multQ[0];
  end

  // Sequencer: latch the operands on start, step WIDTH times, then commit HI/LO and pulse done.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      multState <= IDLE;
      accA      <= '0;
      multM     <= '0;
      multQ     <= '0;
      qMinus1   <= 1'b0;
      stepCount <= '0;
      hiOut     <= '0;
      loOut     <= '0;
      multBusy  <= 1'b0;
      multDone  <= 1'b0;
    end else begin
      multDone <= 1'b0;
      case (multState)
        IDLE: begin
          if (multControl) begin
            multM     <= opA;
            multQ     <= opB;
            accA      <= '0;
            qMinus1   <= 1'b0;
            stepCount <= '0;
            multBusy  <= 1'b1;
            multState <= RUN;
          end
        end
        RUN: begin
          accA      <= nextA;
          multQ     <= nextQ;
          qMinus1   <= nextQMinus1;
          stepCount <= stepCount + CountWidth'(1);
          if (stepCount == LastStep) begin
            hiOut     <= nextA[WIDTH-1:0];
            loOut     <= nextQ;
            multBusy  <= 1'b0;
            multDone  <= 1'b1;
            multState <= IDLE;
          end
        end
        default: multState <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: directed self-checking bench for mult_unit.
// It drives table-driven product vectors back to back.
// It also runs hand-written sequences for an ignored restart request and for a reset that arrives mid-operation.

module tb_mult_unit;

  localparam int WIDTH = 32;
  localparam int Latency = 32;
  localparam int WaitBudget = 40;

  logic             clock;
  logic             Reset;
  logic             multControl;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] hiOut;
  logic [WIDTH-1:0] loOut;
  logic             multBusy;
  logic             multDone;

  int checkCount = 0;
  int errorCount = 0;

  logic [WIDTH-1:0] prevHi;
  logic [WIDTH-1:0] prevLo;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] expHi;
    logic [WIDTH-1:0] expLo;
  } vector_t;

  vector_t vectors[10];

  mult_unit #(.WIDTH(WIDTH)) dut (
    .clock       (clock),
    .Reset       (Reset),
    .multControl (multControl),
    .opA         (opA),
    .opB         (opB),
    .hiOut       (hiOut),
    .loOut       (loOut),
    .multBusy    (multBusy),
    .multDone    (multDone)
  );

  // The clock period is 10 time units. Inputs are driven, and outputs sampled, 1 unit after each rising edge.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Start one product, then follow it to completion.
  // Busy, latency, held outputs, the result and the done pulse width are all checked.
  task automatic applyStimulus(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] expHi, input logic [WIDTH-1:0] expLo);
    int  cycles;
    bit  busyDropped;
    bit  outputsMoved;
    opA = a;
    opB = b;
    multControl = 1'b1;
    tick();
    multControl = 1'b0;
    opA = ~a;
    opB = ~b;
    checkOutput({name, " busy@E0"}, {63'd0, multBusy}, 64'd1);
    checkOutput({name, " done@E0"}, {63'd0, multDone}, 64'd0);
    checkOutput({name, " held@E0"}, {hiOut, loOut}, {prevHi, prevLo});
    cycles = 0;
    busyDropped = 1'b0;
    outputsMoved = 1'b0;
    while (!multDone && cycles < WaitBudget) begin
      tick();
      cycles++;
      if (!multDone) begin
        if (!multBusy) busyDropped = 1'b1;
        if ({hiOut, loOut} !== {prevHi, prevLo}) outputsMoved = 1'b1;
      end
    end
    checkOutput({name, " latency"}, 64'(cycles), 64'(Latency));
    checkOutput({name, " busy during run"}, {63'd0, busyDropped}, 64'd0);
    checkOutput({name, " outputs stable during run"}, {63'd0, outputsMoved}, 64'd0);
    checkOutput({name, " busy@done"}, {63'd0, multBusy}, 64'd0);
    checkOutput({name, " product"}, {hiOut, loOut}, {expHi, expLo});
    prevHi = expHi;
    prevLo = expLo;
  endtask

  // Watch a window of cycles and count any done pulses that appear.
  task automatic countDonePulses(input int window, output int pulses);
    pulses = 0;
    for (int i = 0; i < window; i++) begin
      tick();
      if (multDone) pulses++;
    end
  endtask

  initial begin
    int pulses;
    int cycles;

    vectors[0] = '{32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C};
    vectors[1] = '{32'hFFFFFFFD, 32'h00000004, 32'hFFFFFFFF, 32'hFFFFFFF4};
    vectors[2] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vectors[3] = '{32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
    vectors[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vectors[5] = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vectors[6] = '{32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vectors[7] = '{32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000};
    vectors[8] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    vectors[9] = '{32'hFFFFFFF9, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFDD};

    Reset = 1'b0;
    multControl = 1'b0;
    opA = '0;
    opB = '0;
    prevHi = '0;
    prevLo = '0;
    tick();
    tick();
    checkOutput("reset outputs", {hiOut, loOut}, 64'd0);
    checkOutput("reset busy/done", {62'd0, multBusy, multDone}, 64'd0);
    Reset = 1'b1;
    tick();
    checkOutput("idle after reset", {62'd0, multBusy, multDone}, 64'd0);

    // Each vector begins on the edge right after the previous done, so the starts are back to back.
    for (int i = 0; i < 10; i++) begin
      applyStimulus($sformatf("vec%0d", i), vectors[i].a, vectors[i].b, vectors[i].expHi, vectors[i].expLo);
    end

    tick();
    checkOutput("done one cycle", {63'd0, multDone}, 64'd0);
    tick();

    // A restart request in the middle of a run is ignored: the operands latched at the start still win.
    opA = 32'd5;
    opB = 32'd7;
    multControl = 1'b1;
    tick();
    multControl = 1'b0;
    cycles = 0;
    pulses = 0;
    while (cycles < WaitBudget && pulses == 0) begin
      if (cycles == 9) begin
        multControl = 1'b1;
        opA = 32'd2;
        opB = 32'd2;
      end else if (cycles == 10) begin
        multControl = 1'b0;
        opA = 32'h99;
      end
      tick();
      cycles++;
      if (multDone) pulses++;
    end
    checkOutput("restart latency", 64'(cycles), 64'(Latency));
    checkOutput("restart ignored product", {hiOut, loOut}, 64'h23);
    countDonePulses(WaitBudget, pulses);
    checkOutput("restart single done", 64'(pulses), 64'd0);
    checkOutput("restart idle", {63'd0, multBusy}, 64'd0);

    // A reset in the middle of an operation discards it at once, and no done pulse follows.
    opA = 32'd6;
    opB = 32'd6;
    multControl = 1'b1;
    tick();
    multControl = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    Reset = 1'b0;
    #1;
    checkOutput("midrun reset outputs", {hiOut, loOut}, 64'd0);
    checkOutput("midrun reset busy/done", {62'd0, multBusy, multDone}, 64'd0);
    tick();
    Reset = 1'b1;
    countDonePulses(WaitBudget, pulses);
    checkOutput("no done after reset", 64'(pulses), 64'd0);
    checkOutput("outputs still clear", {hiOut, loOut}, 64'd0);
    prevHi = '0;
    prevLo = '0;
    applyStimulus("post-reset 2*2", 32'd2, 32'd2, 32'd0, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
